// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the execute bus, waits for the data-SRAM
// read response, aligns/extends load data and forwards results to writeback.
module mem_stage #(
  parameter int EX_MEM_W = 190,
  parameter int MEM_WB_W = 184,
  parameter int MEM_ID_W = 39
) (
  input  logic                clk,
  input  logic                resetn,
  output logic                mem_allowin,
  input  logic                ex_mem_valid,
  input  logic [EX_MEM_W-1:0] ex_mem_bus,
  output logic                mem_wb_valid,
  input  logic                wb_allowin,
  output logic [MEM_WB_W-1:0] mem_wb_bus,
  input  logic [31:0]         data_sram_rdata,
  input  logic                data_sram_rvalid,
  output logic [MEM_ID_W-1:0] mem_id_bus,
  input  logic                ertn_flush
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  logic                mem_valid_r;
  logic [EX_MEM_W-1:0] bus_r;
  state_t              state_r;
  state_t              state_nxt_s;
  logic                cancel_r;
  logic                cancel_nxt_s;
  logic [31:0]         rdata_buf_r;
  logic [31:0]         rdata_buf_nxt_s;
  logic                mem_ready_go_s;
  logic                load_enter_s;
  logic [31:0]         raw_s;
  logic [31:0]         final_result_s;
  logic                mem_bypass_s;
  logic                mem_ld_pending_s;

  logic                gr_we_s;
  logic                res_from_mem_s;
  logic [2:0]          mem_type_s;
  logic [1:0]          addr_low2_s;
  logic [4:0]          dest_s;
  logic [31:0]         pc_s;
  logic [31:0]         inst_s;
  logic [31:0]         result_s;
  logic [81:0]         tail_s;

  // mem_type[1:0]: 00 byte, 01 half, else word; mem_type[2] selects zero-extension
  function automatic logic [31:0] load_extract(input logic [31:0] raw,
                                               input logic [2:0]  mtype,
                                               input logic [1:0]  alow);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (alow)
      2'd0:    b = raw[7:0];
      2'd1:    b = raw[15:8];
      2'd2:    b = raw[23:16];
      default: b = raw[31:24];
    endcase
    h = alow[1] ? raw[31:16] : raw[15:0];
    case (mtype[1:0])
      2'b00:   r = mtype[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = mtype[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = raw;
    endcase
    return r;
  endfunction

  assign gr_we_s        = bus_r[189];
  assign res_from_mem_s = bus_r[188];
  assign mem_type_s     = bus_r[187:185];
  assign addr_low2_s    = bus_r[184:183];
  assign dest_s         = bus_r[182:178];
  assign pc_s           = bus_r[177:146];
  assign inst_s         = bus_r[145:114];
  assign result_s       = bus_r[113:82];
  assign tail_s         = bus_r[81:0];

  // Ready-to-go: non-loads pass immediately, loads wait for an uncancelled response
  always_comb begin
    mem_ready_go_s = 1'b1;
    if (res_from_mem_s) begin
      case (state_r)
        S_WAIT:  mem_ready_go_s = data_sram_rvalid & ~cancel_r;
        S_HOLD:  mem_ready_go_s = 1'b1;
        default: mem_ready_go_s = 1'b0;
      endcase
    end else begin
      mem_ready_go_s = 1'b1;
    end
  end

  assign mem_allowin  = ~mem_valid_r | (mem_ready_go_s & wb_allowin);
  assign mem_wb_valid = mem_valid_r & mem_ready_go_s;
  assign load_enter_s = ex_mem_valid & mem_allowin & ex_mem_bus[188];

  // Load-response FSM and cancel flag for responses orphaned by a flush
  always_comb begin
    state_nxt_s     = state_r;
    cancel_nxt_s    = cancel_r;
    rdata_buf_nxt_s = rdata_buf_r;
    if (ertn_flush) begin
      state_nxt_s = S_IDLE;
      if (state_r == S_WAIT) begin
        // Only a response that belongs to the flushed load leaves nothing in flight
        cancel_nxt_s = ~(data_sram_rvalid & ~cancel_r);
      end else if (data_sram_rvalid) begin
        cancel_nxt_s = 1'b0;
      end else begin
        cancel_nxt_s = cancel_r;
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          if (data_sram_rvalid) begin
            cancel_nxt_s = 1'b0;
          end else begin
            cancel_nxt_s = cancel_r;
          end
          if (load_enter_s) begin
            state_nxt_s = S_WAIT;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_WAIT: begin
          if (data_sram_rvalid & cancel_r) begin
            cancel_nxt_s = 1'b0;
            state_nxt_s  = S_WAIT;
          end else if (data_sram_rvalid) begin
            if (wb_allowin) begin
              state_nxt_s = load_enter_s ? S_WAIT : S_IDLE;
            end else begin
              state_nxt_s     = S_HOLD;
              rdata_buf_nxt_s = data_sram_rdata;
            end
          end else begin
            state_nxt_s = S_WAIT;
          end
        end
        S_HOLD: begin
          if (wb_allowin) begin
            state_nxt_s = load_enter_s ? S_WAIT : S_IDLE;
          end else begin
            state_nxt_s = S_HOLD;
          end
        end
        default: begin
          state_nxt_s  = S_IDLE;
          cancel_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // FSM, cancel flag and response buffer registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= S_IDLE;
      cancel_r    <= 1'b0;
      rdata_buf_r <= 32'd0;
    end else begin
      state_r     <= state_nxt_s;
      cancel_r    <= cancel_nxt_s;
      rdata_buf_r <= rdata_buf_nxt_s;
    end
  end

  // Stage valid bit and execute-bus latch
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_r <= 1'b0;
      bus_r       <= '0;
    end else begin
      if (ertn_flush) begin
        mem_valid_r <= 1'b0;
      end else if (mem_allowin) begin
        mem_valid_r <= ex_mem_valid;
      end else begin
        mem_valid_r <= mem_valid_r;
      end
      if (ex_mem_valid & mem_allowin) begin
        bus_r <= ex_mem_bus;
      end else begin
        bus_r <= bus_r;
      end
    end
  end

  assign raw_s            = (state_r == S_HOLD) ? rdata_buf_r : data_sram_rdata;
  assign final_result_s   = res_from_mem_s ? load_extract(raw_s, mem_type_s, addr_low2_s) : result_s;
  assign mem_bypass_s     = mem_valid_r & gr_we_s & (dest_s != 5'd0);
  assign mem_ld_pending_s = mem_valid_r & res_from_mem_s & ~mem_ready_go_s;

  assign mem_wb_bus = {gr_we_s, dest_s, pc_s, inst_s, final_result_s, tail_s};
  assign mem_id_bus = {mem_bypass_s, mem_ld_pending_s, dest_s, final_result_s};

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage; sits directly downstream of the execute stage and upstream of writeback.
- Latches the execute-to-memory bus and waits for the variable-latency data-SRAM read response.
- Aligns and extends load data, then forwards results to writeback.
- Exports a bypass/load-pending bus to decode; handles ertn flush, including discarding read responses still in flight.

Parameters:
- EX_MEM_W, 190, width of ex_mem_bus.
- MEM_WB_W, 184, width of mem_wb_bus.
- MEM_ID_W, 39, width of mem_id_bus.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- mem_allowin  out  1  stage can accept a new instruction this cycle
- ex_mem_valid  in  1  upstream instruction valid
- ex_mem_bus  in  EX_MEM_W  upstream bus, MSB first: {gr_we, res_from_mem, mem_type[2:0], addr_low2[1:0], dest[4:0], pc[31:0], inst[31:0], result[31:0], csr_we, csr_re, csr_num[13:0], csr_wmask[31:0], csr_wvalue[31:0], ertn, syscall}
- mem_wb_valid  out  1  downstream instruction valid
- wb_allowin  in  1  writeback can accept
- mem_wb_bus  out  MEM_WB_W  {gr_we, dest, pc, inst, final_result, csr_we, csr_re, csr_num, csr_wmask, csr_wvalue, ertn, syscall}
- data_sram_rdata  in  32  read data, valid when data_sram_rvalid=1
- data_sram_rvalid  in  1  one-cycle read-response strobe; exactly one per load issued
- mem_id_bus  out  MEM_ID_W  {mem_bypass, mem_ld_pending, dest, final_result}
- ertn_flush  in  1  flush from writeback

Behaviour:
- Reset (async, resetn=0): mem_valid=0, state=IDLE, cancel=0, rdata_buf=0. Outputs: mem_wb_valid=0, mem_allowin=1, mem_id_bus bypass/pending bits=0.
- Bus register loads on ex_mem_valid & mem_allowin; it holds otherwise.
- mem_valid update:
  - ertn_flush forces mem_valid <= 0.
  - Otherwise, if mem_allowin, mem_valid <= ex_mem_valid.
- mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin).
- mem_wb_valid = mem_valid & mem_ready_go.
- Latency: non-loads give mem_ready_go=1 in the entry cycle. Loads complete in the cycle rvalid arrives (zero-cycle pass-through) or later from rdata_buf.
- FSM, tracking only valid loads (res_from_mem=1):
  - IDLE: load enters -> WAIT.
  - WAIT: mem_ready_go = rvalid & ~cancel.
    - rvalid & wb_allowin -> IDLE; a back-to-back load enters -> WAIT.
    - rvalid & ~wb_allowin -> HOLD, capturing rdata into rdata_buf.
  - HOLD: mem_ready_go=1; data comes from rdata_buf. wb_allowin -> IDLE, or WAIT if the next load enters.
- cancel flag:
  - Set when ertn_flush arrives while the state is WAIT and rvalid is not in the same cycle.
  - The next rvalid is swallowed: it is not forwarded and clears cancel.
  - While cancel=1, a newly entered load stays in WAIT, and the response that clears cancel is not used for it.
  - Flush in HOLD: buffer discarded, state -> IDLE, cancel stays 0.
  - Flush in the same cycle as rvalid: response discarded, no cancel.
- Load extraction from raw = (state==HOLD) ? rdata_buf : data_sram_rdata. mem_type encoding:
  - [1:0]: 00 byte, 01 half, 10 word.
  - [2]: 1 = zero-extend, 0 = sign-extend.
  - Byte select = raw[8*addr_low2 +: 8].
  - Half select = addr_low2[1] ? raw[31:16] : raw[15:0].
- final_result = res_from_mem ? extracted : result.
- Bypass bits:
  - mem_bypass = mem_valid & gr_we & (dest!=0).
  - mem_ld_pending = mem_valid & res_from_mem & ~mem_ready_go. Decode stalls on a match while this is set.
- Unexpected rvalid in IDLE with cancel=0 is ignored. The bench flags it as a protocol error.

Test Plan:
- ALU op (result=0x1234, dest=5) with wb_allowin=1 -> mem_wb_valid the same cycle; final_result=0x1234; mem_bypass=1.
- ld.b with addr_low2=3, rdata=0x80FF0000 and rvalid 2 cycles later -> mem_ld_pending=1 for 2 cycles, then final_result=0xFFFFFF80. ld.bu on the same data -> 0x00000080.
- ld.h, addr_low2=2, rdata=0x7FFE1234, rvalid while wb_allowin=0 for 3 cycles -> HOLD; rdata changes ignored; on release final_result=0x00007FFE.
- Load in WAIT, ertn_flush, new ld.w enters the next cycle; rvalid(0xDEAD) then rvalid(0xBEEF) -> first response dropped; ld.w completes with 0xBEEF.
- Back-to-back ld.w with rvalid each cycle and wb_allowin=1 -> one mem_wb_valid per cycle, no bubbles.
- resetn deasserted asynchronously mid-WAIT -> all outputs return to reset values immediately; cancel=0.
